// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide unit with HI/LO ownership for the E stage.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (codes 8..11).
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_sel_MDU,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_cancel,
    input  logic        D_instr_mdu,
    output logic        busy,
    output logic        start,
    output logic        stall_req,
    output logic [31:0] E_MDU_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [63:0] res_q, res_d;
    logic        nowr_q, nowr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_mul, is_div, is_mac, sgn;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_den, q_mag, r_mag, quo, rem;
    logic [63:0] smul, umul, acc;

    assign is_mul = (E_sel_MDU == OP_MULT) || (E_sel_MDU == OP_MULTU);
    assign is_div = (E_sel_MDU == OP_DIV) || (E_sel_MDU == OP_DIVU);
`ifdef MDU_MADD_EN
    assign is_mac = (E_sel_MDU >= OP_MADD) && (E_sel_MDU <= OP_MSUBU);
`else
    assign is_mac = 1'b0;
`endif
    assign start     = (is_mul | is_div | is_mac) & ~E_cancel & ~busy_q;
    assign stall_req = D_instr_mdu & (busy_q | start);
    assign busy      = busy_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

    // Even codes are the signed variants across mult, div and the mac family.
    always_comb begin
        sgn   = ~E_sel_MDU[0];
        smul  = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
        umul  = {32'd0, E_A} * {32'd0, E_B};
        a_neg = sgn & E_A[31];
        b_neg = sgn & E_B[31];
        a_mag = a_neg ? -E_A : E_A;
        b_mag = b_neg ? -E_B : E_B;
        b_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_den;
        r_mag = a_mag % b_den;
        quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        E_MDU_out = 32'd0;
        case (E_sel_MDU)
            OP_MFHI: E_MDU_out = hi_q;
            OP_MFLO: E_MDU_out = lo_q;
            default: E_MDU_out = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        res_d   = res_q;
        nowr_d  = nowr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc     = {hi_q, lo_q};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    busy_d  = 1'b1;
                    op_d    = E_sel_MDU;
                    nowr_d  = is_div && (E_B == 32'd0);
                    if (is_div) begin
                        res_d = {rem, quo};
                        cnt_d = 4'(DIV_CYCLES);
                    end else begin
                        res_d = sgn ? smul : umul;
                        cnt_d = 4'(MULT_CYCLES);
                    end
                end else if (!E_cancel && E_sel_MDU == OP_MTHI) begin
                    hi_d = E_A;
                end else if (!E_cancel && E_sel_MDU == OP_MTLO) begin
                    lo_d = E_A;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    case (op_q)
                        OP_MADD, OP_MADDU: acc = acc + res_q;
                        OP_MSUB, OP_MSUBU: acc = acc - res_q;
                        default: acc = nowr_q ? acc : res_q;
                    endcase
                    {hi_d, lo_d} = acc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            res_q   <= 64'd0;
            nowr_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
            nowr_q  <= nowr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus queues expected commits,
// a negedge monitor checks HI/LO and busy length when busy falls.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_sel_MDU = 4'd15;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        E_cancel = 1'b0;
    logic        D_instr_mdu = 1'b0;
    logic        busy, start, stall_req;
    logic [31:0] E_MDU_out, HI, LO;

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_sel_MDU(E_sel_MDU),
        .E_A(E_A), .E_B(E_B), .E_cancel(E_cancel),
        .D_instr_mdu(D_instr_mdu), .busy(busy), .start(start),
        .stall_req(stall_req), .E_MDU_out(E_MDU_out),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each falling edge of busy must match the oldest expectation.
    logic prev_busy = 1'b0;
    int   busy_cnt  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            busy_cnt++;
        end else if (prev_busy) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_commit: got busy_len %0d expected none",
                         busy_cnt);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, HI, e.hi);
                chk({e.name, "_lo"}, LO, e.lo);
                chk({e.name, "_cycles"}, 32'(busy_cnt), 32'(e.cyc));
            end
            busy_cnt = 0;
        end
        prev_busy = busy;
    end

    // Issue a timed op at #1 after an edge and hold it for the start edge.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int n, input bit watch_stall);
        sb.push_back('{name, ehi, elo, n});
        E_sel_MDU = op;
        E_A = a;
        E_B = b;
        #1;
        chk({name, "_start"}, {31'd0, start}, 32'd1);
        if (watch_stall) chk({name, "_stall_start"}, {31'd0, stall_req}, 32'd1);
        step();
        E_sel_MDU = 4'd15;
        for (int i = 0; i < n; i++) begin
            if (watch_stall)
                chk({name, "_stall_busy"}, {31'd0, stall_req}, 32'd1);
            step();
        end
        if (watch_stall) chk({name, "_stall_end"}, {31'd0, stall_req}, 32'd0);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a,
                      input logic cancel);
        E_sel_MDU = op;
        E_A = a;
        E_cancel = cancel;
        step();
        E_sel_MDU = 4'd15;
        E_cancel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        reset = 1'b0;
        step();

        run_op("mult", 4'd0, 32'hFFFF_FFFF, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b0);
        run_op("multu", 4'd1, 32'hFFFF_FFFF, 32'd2,
               32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
        run_op("div", 4'd2, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
        run_op("div0", 4'd2, 32'd5, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);

        D_instr_mdu = 1'b1;
        run_op("divu", 4'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b1);
        E_sel_MDU = 4'd5;
        #1;
        chk("mflo_out", E_MDU_out, 32'd14);
        E_sel_MDU = 4'd4;
        #1;
        chk("mfhi_out", E_MDU_out, 32'd2);
        E_sel_MDU = 4'd12;
        #1;
        chk("code12_out", E_MDU_out, 32'd0);
        E_sel_MDU = 4'd15;
        D_instr_mdu = 1'b0;
        step();

        run_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 10, 1'b0);

        mt(4'd7, 32'h1234, 1'b1);
        chk("mtlo_cancel", LO, 32'h8000_0000);
        mt(4'd6, 32'hABCD, 1'b0);
        chk("mthi", HI, 32'hABCD);
        mt(4'd7, 32'h55, 1'b0);
        chk("mtlo", LO, 32'h55);

        E_sel_MDU = 4'd0;
        E_A = 32'd3;
        E_B = 32'd4;
        E_cancel = 1'b1;
        #1;
        chk("cancel_start", {31'd0, start}, 32'd0);
        step();
        E_sel_MDU = 4'd15;
        E_cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", HI, 32'hABCD);

        E_sel_MDU = 4'd8;
        E_A = 32'd1;
        E_B = 32'd1;
        #1;
        chk("madd_off_start", {31'd0, start}, 32'd0);
        step();
        E_sel_MDU = 4'd15;
        step();
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
        chk("madd_off_lo", LO, 32'h55);

        // mult 3 * -4 cut short by reset in its third busy cycle.
        sb.push_back('{"rst_mid", 32'd0, 32'd0, 3});
        E_sel_MDU = 4'd0;
        E_A = 32'd3;
        E_B = 32'hFFFF_FFFC;
        step();
        E_sel_MDU = 4'd15;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (10) step();
        chk("rst_mid_hi_late", HI, 32'd0);
        chk("rst_mid_lo_late", LO, 32'd0);

        run_op("mult_neg", 4'd0, 32'd3, 32'hFFFF_FFFC,
               32'hFFFF_FFFF, 32'hFFFF_FFF4, 5, 1'b0);

        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide unit and its sequencer for the 5-stage MIPS pipeline. It sits in E, driven by the `E_sel_MDU` decode. It owns the HI/LO registers, runs timed mult/div operations, and services mthi/mtlo/mfhi/mflo. While an operation is in flight it raises a stall request for MDU instructions waiting in D.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); legal range 1..15
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
E_sel_MDU  in  4  op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo, 8 madd, 9 maddu, 10 msub, 11 msubu, 15 none
E_A  in  32  forwarded rs value in E
E_B  in  32  forwarded rt value in E
E_cancel  in  1  E instruction squashed (exception/eret/interrupt in M); blocks start and mt writes
D_instr_mdu  in  1  D-stage instruction is md/mt/mf
busy  out  1  operation in flight
start  out  1  combinational; a timed op is accepted this cycle
stall_req  out  1  D_instr_mdu & (busy | start)
E_MDU_out  out  32  HI for code 4, LO for code 5, else 0
HI  out  32  architectural HI
LO  out  32  architectural LO

Behaviour:
- Reset values: HI=0, LO=0, busy=0, state IDLE, counter=0, operand/result latches 0.
- States:
  - IDLE: on `start` (codes 0–3, or 8–11 when enabled, with !E_cancel and !busy), latch operands and op, load counter with MULT_CYCLES or DIV_CYCLES, go to BUSY. No other event leaves IDLE.
  - BUSY: busy=1; counter decrements each cycle. On the edge where counter==1, commit the result to HI/LO, set busy=0 and return to IDLE.
- Latency: start at edge t; busy is high for cycles t+1..t+N; HI/LO are new at edge t+N. An mfhi in E during cycle t+N+1 reads the new value.
- Operations issued back-to-back: a new start is only possible with busy=0. D is stalled until then, so no overlap occurs.
- Once started, an operation always completes. E_cancel never aborts an in-flight operation.
- E_cancel=1 suppresses start and mthi/mtlo writes in the same cycle.
- mthi/mtlo: write HI/LO (E_A) at the clock edge when !E_cancel. busy is always 0 at that point because of stall_req.
- Arithmetic:
  - mult: signed 64-bit product; multu: unsigned; {HI,LO}=product.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: unsigned.
  - Divisor 0: HI and LO are unchanged; the timing is unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- A computed result may be precomputed combinationally at start and held; only the commit timing is architecturally visible.
- Reset asserted mid-operation: return to IDLE with HI/LO=0 at that edge; no commit.
- Codes 12–14 and 15: no effect.

Optional Feature:
MDU_MADD_EN
- Defined: codes 8/9 accumulate {HI,LO} += signed/unsigned product; codes 10/11 accumulate {HI,LO} -= product. All four use MULT_CYCLES. The accumulator base is the {HI,LO} value at commit time, and 64-bit wrap-around applies.
- Undefined: codes 8–11 behave as code 15 and never assert start.

Test Plan:
- Reset, then mult E_A=0xFFFFFFFF, E_B=2: busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands: HI=1, LO=0xFFFFFFFE.
- div E_A=-7, E_B=2: after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div by 0: HI/LO unchanged and busy still lasts 10 cycles.
- div issued with D_instr_mdu=1 (mflo waiting in D): stall_req=1 from the start cycle through the last busy cycle; mflo in E then returns the new LO.
- mtlo E_A=0x1234 with E_cancel=1: LO unchanged. A mult with E_cancel=1: start=0, busy stays 0.
- Reset asserted at the third busy cycle of a mult: next cycle busy=0, HI=LO=0, and no later commit.
- With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, maddu 1×1: HI=1, LO=0 after 5 cycles. Without the macro, code 8: start=0, HI/LO unchanged.
